// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults and helpers for the arcade video path.
// Defaults describe the 15 kHz mode: 256x224 visible inside a 384x264 raster.
package video_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 256;
  localparam int unsigned DEF_H_FP     = 24;
  localparam int unsigned DEF_H_SYNC   = 32;
  localparam int unsigned DEF_H_BP     = 72;

  localparam int unsigned DEF_V_ACTIVE = 224;
  localparam int unsigned DEF_V_FP     = 16;
  localparam int unsigned DEF_V_SYNC   = 8;
  localparam int unsigned DEF_V_BP     = 16;

  localparam int unsigned DEF_COLOR_W  = 4;

  localparam int unsigned CSYNC_AND = 0;
  localparam int unsigned CSYNC_XOR = 1;

  function automatic int unsigned seg_total(input int unsigned active, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_sync_gen_if.sv
// Pixel-in / raster-out bundle of the sync generator.
// master = the generator side, slave = the pixel source / monitor side.
interface video_sync_gen_if #(
  parameter int unsigned HW      = 9,
  parameter int unsigned VW      = 9,
  parameter int unsigned COLOR_W = 4
);
  logic               pix_ce;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [HW-1:0]      hcount;
  logic [VW-1:0]      vcount;
  logic               de;
  logic               line_start;
  logic               frame_start;
  logic               hsync_n;
  logic               vsync_n;
  logic               csync;
  logic [COLOR_W-1:0] video_r;
  logic [COLOR_W-1:0] video_g;
  logic [COLOR_W-1:0] video_b;

  modport master (
    input  pix_ce, pix_r, pix_g, pix_b,
    output hcount, vcount, de, line_start, frame_start,
           hsync_n, vsync_n, csync, video_r, video_g, video_b
  );

  modport slave (
    output pix_ce, pix_r, pix_g, pix_b,
    input  hcount, vcount, de, line_start, frame_start,
           hsync_n, vsync_n, csync, video_r, video_g, video_b
  );
endinterface

// File: rtl/raster_axis_counter.sv
// One raster axis: wrapping position counter plus blank/sync decode of the
// current position. Used once per line (H) and once per frame (V).
module raster_axis_counter
  import video_timing_pkg::*;
#(
  parameter  int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter  int unsigned FP     = DEF_H_FP,
  parameter  int unsigned SYNC   = DEF_H_SYNC,
  parameter  int unsigned BP     = DEF_H_BP,
  localparam int unsigned TOTAL  = seg_total(ACTIVE, FP, SYNC, BP),
  localparam int unsigned W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic         blank,
  output logic         sync_raw
);

  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC - 1);

  if (ACTIVE == 0) begin : g_bad_active
    $error("raster_axis_counter: ACTIVE must be non-zero");
  end
  if (SYNC == 0) begin : g_bad_sync
    $error("raster_axis_counter: SYNC must be non-zero");
  end

  logic [W-1:0] cnt;

  assign wrap = inc && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + W'(1);
    end
  end

  assign count    = cnt;
  assign blank    = cnt >= ACT_END;
  // A zero-width porch collapses naturally: the sync window then abuts its neighbour.
  assign sync_raw = (cnt >= SYNC_LO) && (cnt <= SYNC_HI);

endmodule

// File: rtl/video_sync_gen.sv
// Raster timing generator: H/V counters and display enable at stage 0,
// registered syncs, composite sync and blanked RGB one pixel later.
module video_sync_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter int unsigned COLOR_W    = DEF_COLOR_W,
  parameter int unsigned CSYNC_MODE = CSYNC_AND
) (
  input  logic             clk,
  input  logic             reset,
  video_sync_gen_if.master vif
);

  localparam int unsigned H_TOTAL = seg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = seg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  if (CSYNC_MODE > CSYNC_XOR) begin : g_bad_csync
    $error("video_sync_gen: CSYNC_MODE must be CSYNC_AND or CSYNC_XOR");
  end

  logic [HW-1:0]      hcnt;
  logic [VW-1:0]      vcnt;
  logic               h_wrap, v_wrap;
  logic               hblank, vblank;
  logic               hs_raw, vs_raw;
  logic               de;
  logic               csync_nxt;
  logic               line_start_q, frame_start_q;
  logic               hsync_q, vsync_q, csync_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  raster_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP)
  ) u_hcnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (vif.pix_ce),
    .count    (hcnt),
    .wrap     (h_wrap),
    .blank    (hblank),
    .sync_raw (hs_raw)
  );

  raster_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP)
  ) u_vcnt (
    .clk      (clk),
    .reset    (reset),
    .inc      (h_wrap),
    .count    (vcnt),
    .wrap     (v_wrap),
    .blank    (vblank),
    .sync_raw (vs_raw)
  );

  assign de = ~hblank & ~vblank;

  always_comb begin
    csync_nxt = ~(hs_raw | vs_raw);
    if (CSYNC_MODE == CSYNC_XOR) begin
      csync_nxt = ~(hs_raw ^ vs_raw);
    end
  end

  // Pulses are written every clk so they self-clear on the cycle after the wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      csync_q       <= 1'b1;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
      if (vif.pix_ce) begin
        hsync_q <= ~hs_raw;
        vsync_q <= ~vs_raw;
        csync_q <= csync_nxt;
        r_q     <= de ? vif.pix_r : '0;
        g_q     <= de ? vif.pix_g : '0;
        b_q     <= de ? vif.pix_b : '0;
      end
    end
  end

  assign vif.hcount      = hcnt;
  assign vif.vcount      = vcnt;
  assign vif.de          = de;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.hsync_n     = hsync_q;
  assign vif.vsync_n     = vsync_q;
  assign vif.csync       = csync_q;
  assign vif.video_r     = r_q;
  assign vif.video_g     = g_q;
  assign vif.video_b     = b_q;

endmodule
